// File: rtl/io_fifo_port_pkg.sv
// io_fifo_port_pkg: register offsets, status/control bit positions and bus FSM states
package io_fifo_port_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam int ST_RX_NE    = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam int CTRL_CLR   = 2;
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, ACCESS, HOLD} bus_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: pointer-based synchronous FIFO with flush; extra pointer MSB distinguishes full from empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q, wp_d, rp_d;
  logic do_push, do_pop;
  assign empty_o = wp_q == rp_q;
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign count_o = wp_q - rp_q;
  assign dout_o  = mem_q[rp_q[AW-1:0]];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wp_d = flush_i ? '0 : wp_q + {{AW{1'b0}}, do_push};
  assign rp_d = flush_i ? '0 : rp_q + {{AW{1'b0}}, do_pop};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/io_fifo_port.sv
// io_fifo_port: 8088 I/O-mapped byte FIFO peripheral; bus cycles push TX / pop RX,
// stream side runs independently, READY inserts a fixed number of wait states.
module io_fifo_port
  import io_fifo_port_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         WAIT_STATES = 1,
  parameter logic [3:0] BASE_OFFSET = 4'h0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CS,
  input  logic        ALE,
  input  logic        RD,
  input  logic        WR,
  input  logic [19:0] Address,
  inout  wire  [7:0]  Data,
  output logic        READY,
  output logic        IRQ,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  bus_state_t state_q;
  logic rd_q, wr_q, is_rd_q, rx_pop_q, ready_q, irq_q, rx_ovf_q, tx_ovf_q, rx_ovf_d, tx_ovf_d;
  logic [1:0] reg_q, ctrl_q;
  logic [7:0] rdata_q, wcnt_q, status, rd_val, rx_dout;
  logic hit, fall, strobe_hi, acc_wr, end_rd, clr_ovf, flush;
  logic tx_push, tx_pop, rx_push, rx_pop, tx_empty, tx_full, rx_empty, rx_full;
  logic [CW-1:0] tx_count, rx_count;
  logic unused_ok;
  assign unused_ok = ^{Address[19:4], tx_count, rx_count};
  assign hit       = CS && Address[3:2] == BASE_OFFSET[1:0];
  assign fall      = (rd_q && !RD) || (wr_q && !WR);
  assign strobe_hi = is_rd_q ? RD : WR;
  assign acc_wr    = state_q == ACCESS && !is_rd_q;
  assign end_rd    = state_q == HOLD && strobe_hi && is_rd_q;
  assign flush     = acc_wr && reg_q == REG_CTRL && Data[CTRL_CLR];
  assign clr_ovf   = flush || (end_rd && reg_q == REG_STATUS);
  assign tx_push   = acc_wr && reg_q == REG_DATA && !tx_full;
  assign tx_pop    = tx_valid && tx_ready;
  assign rx_push   = rx_valid && !rx_full;
  assign rx_pop    = end_rd && rx_pop_q;
  assign rx_ovf_d  = (rx_ovf_q && !clr_ovf) || (rx_valid && rx_full);
  assign tx_ovf_d  = (tx_ovf_q && !clr_ovf) || (acc_wr && reg_q == REG_DATA && tx_full);
  assign tx_valid  = !tx_empty;
  assign rx_ready  = !rx_full;
  assign READY     = ready_q;
  assign IRQ       = irq_q;
  assign Data = (!RD && is_rd_q && state_q inside {WAIT, ACCESS, HOLD}) ? rdata_q : 8'hzz;
  always_comb begin
    status = '0;
    status[ST_RX_NE]    = !rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_OVF]   = rx_ovf_q;
    status[ST_TX_OVF]   = tx_ovf_q;
    rd_val = Address[1:0] == REG_DATA   ? (rx_empty ? 8'h00 : rx_dout) :
             Address[1:0] == REG_STATUS ? status :
             Address[1:0] == REG_CTRL   ? {6'b0, ctrl_q} : 8'h00;
  end
  // read data and pop eligibility are frozen when the strobe is detected
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q  <= IDLE;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      is_rd_q  <= 1'b0;
      rx_pop_q <= 1'b0;
      ready_q  <= 1'b1;
      irq_q    <= 1'b0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      reg_q    <= '0;
      ctrl_q   <= '0;
      rdata_q  <= '0;
      wcnt_q   <= '0;
    end else begin
      rd_q     <= RD;
      wr_q     <= WR;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      irq_q    <= (ctrl_q[CTRL_RX_IE] && !rx_empty) || (ctrl_q[CTRL_TX_IE] && tx_empty);
      if (acc_wr && reg_q == REG_CTRL) ctrl_q <= Data[1:0];
      case (state_q)
        IDLE: if (ALE) state_q <= ADDR;
        ADDR: if (fall) begin
          is_rd_q  <= rd_q && !RD;
          reg_q    <= Address[1:0];
          rdata_q  <= rd_val;
          rx_pop_q <= rd_q && !RD && Address[1:0] == REG_DATA && !rx_empty;
          if (!hit) state_q <= IDLE;
          else if (WAIT_STATES > 0) begin
            state_q <= WAIT;
            ready_q <= 1'b0;
            wcnt_q  <= 8'(WAIT_STATES - 1);
          end else state_q <= ACCESS;
        end
        WAIT: if (wcnt_q == '0) begin
          state_q <= ACCESS;
          ready_q <= 1'b1;
        end else wcnt_q <= wcnt_q - 8'd1;
        ACCESS: state_q <= HOLD;
        HOLD: if (strobe_hi) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx (
    .clk_i(CLK), .rst_ni(RESET_N), .push_i(tx_push), .pop_i(tx_pop), .flush_i(flush),
    .din_i(Data), .dout_o(tx_data), .empty_o(tx_empty), .full_o(tx_full), .count_o(tx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx (
    .clk_i(CLK), .rst_ni(RESET_N), .push_i(rx_push), .pop_i(rx_pop), .flush_i(flush),
    .din_i(rx_data), .dout_o(rx_dout), .empty_o(rx_empty), .full_o(rx_full), .count_o(rx_count)
  );
endmodule

// File: tb/tb_io_fifo_port.sv
// tb_io_fifo_port: randomized bus/stream traffic against a queue-based model of the peripheral
module tb_io_fifo_port;
  localparam int DEPTH = 8;
  localparam int WS = 2;
  logic CLK = 1'b0;
  logic RESET_N, CS, ALE, RD, WR, READY, IRQ, tx_valid, tx_ready, rx_valid, rx_ready, drv_en;
  logic [19:0] Address;
  logic [7:0] tx_data, rx_data, drv, q;
  tri1 [7:0] data_w;
  int checks = 0, errs = 0;
  logic [7:0] txq[$], rxq[$];
  logic rx_ovf, tx_ovf;
  logic [1:0] ctrl;
  always #5 CLK = ~CLK;
  assign data_w = drv_en ? drv : 8'hzz;
  io_fifo_port #(.DEPTH(DEPTH), .WAIT_STATES(WS), .BASE_OFFSET(4'h0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CS(CS), .ALE(ALE), .RD(RD), .WR(WR), .Address(Address),
    .Data(data_w), .READY(READY), .IRQ(IRQ), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] exp_status();
    return {2'b00, tx_ovf, rx_ovf, txq.size() == DEPTH, txq.size() == 0,
            rxq.size() == DEPTH, rxq.size() != 0};
  endfunction
  function automatic logic exp_irq();
    return (ctrl[0] && rxq.size() != 0) || (ctrl[1] && txq.size() == 0);
  endfunction
  task automatic model_reset();
    txq.delete(); rxq.delete();
    rx_ovf = 0; tx_ovf = 0; ctrl = 0;
  endtask
  // one bus cycle; fixed cycle counts keep every wait bounded
  task automatic bus(input bit rd, input bit cs, input logic [3:0] a, input logic [7:0] wd,
                     input int hold, output logic [7:0] rq);
    int lows;
    bit hit;
    hit = cs && a[3:2] == 2'b00;
    @(negedge CLK);
    chk("z_pre", data_w, 8'hff);
    Address = {16'h0, a}; CS = cs; ALE = 1;
    @(negedge CLK);
    ALE = 0;
    if (rd) RD = 0;
    else begin WR = 0; drv = wd; drv_en = 1; end
    lows = 0;
    repeat (4) begin @(negedge CLK); if (!READY) lows++; end
    repeat (hold) @(negedge CLK);
    rq = data_w;
    chk("ready_lo", lows, hit ? WS : 0);
    RD = 1; WR = 1; drv_en = 0;
    @(negedge CLK);
    CS = 0;
    chk("z_post", data_w, 8'hff);
  endtask
  task automatic op_wr(input logic [1:0] a, input logic [7:0] v);
    bus(0, 1, {2'b00, a}, v, 0, q);
    if (a == 2'd0) begin
      if (txq.size() < DEPTH) txq.push_back(v); else tx_ovf = 1;
    end else if (a == 2'd2) begin
      ctrl = v[1:0];
      if (v[2]) begin txq.delete(); rxq.delete(); rx_ovf = 0; tx_ovf = 0; end
    end
  endtask
  task automatic op_rd(input logic [1:0] a, input int hold, input string tag);
    logic [7:0] e;
    e = a == 2'd0 ? (rxq.size() != 0 ? rxq[0] : 8'h00) :
        a == 2'd1 ? exp_status() : a == 2'd2 ? {6'b0, ctrl} : 8'h00;
    bus(1, 1, {2'b00, a}, 8'h00, hold, q);
    chk(tag, q, e);
    if (a == 2'd0 && rxq.size() != 0) void'(rxq.pop_front());
    if (a == 2'd1) begin rx_ovf = 0; tx_ovf = 0; end
  endtask
  task automatic op_miss(input bit rd);
    logic [3:0] a;
    bit cs;
    cs = $urandom_range(0, 1) != 0;
    a = {cs ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
    bus(rd, cs, a, 8'($urandom), 0, q);
    if (rd) chk("miss_rd", q, 8'hff);
  endtask
  task automatic op_rx(input logic [7:0] b);
    @(negedge CLK);
    chk("rx_ready", rx_ready, rxq.size() < DEPTH);
    rx_valid = 1; rx_data = b;
    @(negedge CLK);
    rx_valid = 0;
    if (rxq.size() < DEPTH) rxq.push_back(b); else rx_ovf = 1;
  endtask
  task automatic op_tx();
    @(negedge CLK);
    chk("tx_valid", tx_valid, txq.size() != 0);
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    tx_ready = 1;
    @(negedge CLK);
    tx_ready = 0;
    if (txq.size() != 0) void'(txq.pop_front());
  endtask
  task automatic chk_irq(input string tag);
    @(negedge CLK);
    chk(tag, IRQ, exp_irq());
  endtask
  initial begin
    RESET_N = 0; CS = 0; ALE = 0; RD = 1; WR = 1; Address = '0; drv = 0; drv_en = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_ready", READY, 1);
    chk("rst_irq", IRQ, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_z", data_w, 8'hff);
    RESET_N = 1;
    // writes stay queued while the device stalls, then drain in order
    op_wr(0, 8'hA5);
    op_wr(0, 8'h3C);
    op_rd(1, 0, "status_tx_busy");
    chk("status_tx_busy_c", q, 8'h00);
    op_tx(); op_tx();
    op_rd(1, 0, "status_tx_drained");
    chk("status_tx_drained_c", q, 8'h04);
    // stretched read pops once
    op_rx(8'h11); op_rx(8'h22); op_rx(8'h33);
    op_rd(0, 2, "rd_stretch");
    chk("rd_stretch_c", q, 8'h11);
    op_rd(0, 0, "rd_2");
    op_rd(0, 0, "rd_3");
    chk("rd_3_c", q, 8'h33);
    op_rd(0, 0, "rd_empty");
    chk("rd_empty_c", q, 8'h00);
    op_rd(1, 0, "status_rx_empty");
    // TX overflow and read-to-clear
    for (int i = 0; i <= DEPTH; i++) op_wr(0, 8'(i + 8'h40));
    op_rd(1, 0, "status_ovf");
    chk("status_ovf_c", q, 8'h28);
    op_rd(1, 0, "status_ovf_clr");
    chk("status_ovf_clr_c", q, 8'h08);
    // interrupt enable, latency and flush
    op_wr(2, 8'h04);
    op_wr(2, 8'h01);
    chk_irq("irq_idle");
    op_rx(8'h55);
    chk("irq_lat", IRQ, 0);
    @(negedge CLK);
    chk("irq_set", IRQ, 1);
    op_wr(2, 8'h04);
    chk_irq("irq_flush");
    op_rd(1, 0, "status_flushed");
    // reset in the middle of a wait-stated read
    op_rx(8'h77); op_wr(0, 8'h99);
    @(negedge CLK);
    Address = 20'h1; CS = 1; ALE = 1;
    @(negedge CLK);
    ALE = 0; RD = 0;
    @(negedge CLK);
    chk("mid_wait", READY, 0);
    RESET_N = 0;
    #1;
    chk("mid_rst_ready", READY, 1);
    chk("mid_rst_z", data_w, 8'hff);
    @(negedge CLK);
    RD = 1; CS = 0; RESET_N = 1;
    model_reset();
    @(negedge CLK);
    chk("post_rst_tx_valid", tx_valid, 0);
    op_rd(1, 0, "post_rst_status");
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op_wr(0, 8'($urandom));
        2:       op_rd(0, $urandom_range(0, 2), "rnd_data");
        3:       op_rd(2'($urandom_range(1, 3)), 0, "rnd_reg");
        4:       op_wr(2'($urandom_range(1, 3)), {5'b0, $urandom_range(0, 7) == 0, 2'($urandom)});
        5, 6:    op_rx(8'($urandom));
        7, 8:    op_tx();
        default: op_miss($urandom_range(0, 1) != 0);
      endcase
      chk_irq("rnd_irq");
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/io_fifo_port.md
Name: io_fifo_port

Overview:
I/O-mapped byte FIFO peripheral on the 8088 minimum-mode system bus, sitting downstream of the address latch, data transceiver and chip-select decode. It turns CPU IN/OUT bus cycles into pushes and pops on a TX FIFO and an RX FIFO. It exposes a valid/ready stream toward an external device and drives READY to insert wait states.

Parameters:
DEPTH, 16, entries per FIFO (power of 2, >=2)
WAIT_STATES, 1, CLK cycles READY is held low per selected access (0 = none)
BASE_OFFSET, 4'h0, value Address[3:2] must match (as two bits) for register hits

Ports:
CLK  input  1  bus clock, same as CPU
RESET_N  input  1  asynchronous active-low reset
CS  input  1  chip select from decode, active high
ALE  input  1  address latch enable
RD  input  1  read strobe, active low
WR  input  1  write strobe, active low
Address  input  20  latched bus address
Data  inout  8  transceiver-side data bus
READY  output  1  wait-state request, low = stall CPU
IRQ  output  1  interrupt, level, active high
tx_data  output  8  TX stream data
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  device accepts tx_data
rx_data  input  8  RX stream data
rx_valid  input  1  device offers rx_data
rx_ready  output  1  RX FIFO not full

Behaviour:
- Reset (RESET_N low, async): both FIFOs empty; FSM IDLE; READY=1; IRQ=0; tx_valid=0; rx_ready=1; Data high-Z; control register=0; sticky overflow flags=0.
- Register map, Address[1:0], hit only when CS=1 and Address[3:2]==BASE_OFFSET[1:0]:
  - 0 DATA: write pushes TX; read pops RX.
  - 1 STATUS (RO): b0 rx_nonempty, b1 rx_full, b2 tx_empty, b3 tx_full, b4 rx_overflow, b5 tx_overflow, b7:6 0.
  - 2 CONTROL (RW): b0 rx_irq_en, b1 tx_irq_en, b2 clear; b2 self-clears and reads 0.
  - 3: reads 8'h00, writes ignored.
- Bus FSM states: IDLE, ADDR, WAIT, ACCESS, HOLD.
  - IDLE->ADDR: ALE=1.
  - ADDR->WAIT: a strobe falls (RD or WR 1->0, sampled on CLK) with a register hit and WAIT_STATES>0; READY=0 for exactly WAIT_STATES cycles.
  - ADDR->ACCESS: same strobe condition with WAIT_STATES==0.
  - ADDR->IDLE: strobe falls without a hit.
  - WAIT->ACCESS: wait count expires; READY=1 in the same cycle ACCESS is entered.
  - ACCESS: the write side effect commits here exactly once; then go to HOLD.
  - HOLD->IDLE: the strobe returns high; the read pop commits on this RD rising edge, so a stretched RD never pops twice.
- Data is driven only while RD=0 and state is WAIT, ACCESS or HOLD with a hit; otherwise high-Z. Read data is registered at strobe detection and stays stable for the whole strobe.
- DATA read with RX empty returns 8'h00 and does not pop. DATA write with TX full drops the byte and sets tx_overflow.
- Stream side, independent of the bus:
  - TX pop when tx_valid & tx_ready; tx_data shows the head entry combinationally.
  - RX push when rx_valid & rx_ready.
  - rx_overflow sets if rx_valid=1 while the RX FIFO is full; that data is lost.
- Simultaneous push and pop on one FIFO in the same cycle: both occur and the count is unchanged. Pop from a full FIFO plus push is legal. Push plus pop on an empty FIFO: the push happens and the pop is ignored.
- Write CONTROL with b2=1: both FIFOs flush and both overflow flags clear on the ACCESS cycle; irq enables load from the same write.
- Reading STATUS clears the overflow flags at the end of the strobe (HOLD->IDLE).
- IRQ = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty), registered, 1-cycle latency.
- Pointers are log2(DEPTH)+1 bits; wrap is natural modulo. full = MSBs differ and low bits equal.
- Reset asserted mid-cycle: immediate return to reset values; Data released; READY=1.

Decomposition:
- Package io_fifo_port_pkg:
  - register offset localparams (REG_DATA=0, REG_STATUS=1, REG_CTRL=2);
  - status and control bit-index constants;
  - bus_state_t enum {IDLE, ADDR, WAIT, ACCESS, HOLD}.
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - inputs push, pop, flush, din;
  - outputs dout, empty, full, count;
  - instantiated twice (TX and RX).

Test Plan:
- Reset, then OUT DATA 8'hA5, 8'h3C with tx_ready=0 -> STATUS reads 8'h00 except b2=0 (so 8'h00); release tx_ready -> tx_data A5 then 3C; STATUS reads 8'h04.
- WAIT_STATES=2, IN STATUS -> READY low exactly 2 CLKs after RD falls; Data high-Z before RD falls and after RD rises.
- Stream 3 bytes 11,22,33 on rx; IN DATA with RD stretched to 5 cycles -> returns 8'h11, exactly one pop; next two reads 22, 33; fourth read 8'h00 with STATUS b0=0.
- Fill TX with DEPTH+1 writes -> STATUS b3=1, b5=1; read STATUS twice -> second read shows b5=0.
- CONTROL write 8'h01 with RX empty -> IRQ=0; one rx byte arrives -> IRQ=1 one cycle after the push; write 8'h04 -> FIFOs flushed, IRQ=0.
- Assert RESET_N low during WAIT of a read -> READY=1 and Data high-Z immediately; FIFOs empty after release.
